multicycle_control: RTL and testbench

- Multi-cycle sequencer for the RV32I datapath.
- Replaces the combinational single-cycle Control unit.
- Lets instruction fetch and data access share one memory port by walking each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives the PC, IR, register-file, ALU-mux and memory enables; counts retired instructions.

---
 rtl/multicycle_control_pkg.sv | 45 ++++
 rtl/multicycle_control_retire_counter.sv | 20 ++
 rtl/multicycle_control.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared opcodes, state encoding and datapath-select encodings for the
// multi-cycle RV32I sequencer.
package multicycle_control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } alu_src_b_t;

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W, async active-low clear.
module multicycle_control_retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_count <= '0;
    else if (i_inc) r_count <= r_count + CNT_W'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// over one shared memory port and counts retired instructions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNCT3,
  input  logic             FUNCT7_5,
  input  logic             ZERO,
  input  logic             MEM_READY,
  output logic             MEM_REQ,
  output logic             MEM_RW,
  output logic             I_OR_D,
  output logic             IR_WE,
  output logic             PC_WE,
  output logic             PC_SRC,
  output logic             REG_WE,
  output logic             MEMTOREG,
  output logic [1:0]       ALU_SRC_A,
  output logic [1:0]       ALU_SRC_B,
  output logic [1:0]       ALU_OP,
  output logic             ILLEGAL,
  output logic [3:0]       STATE,
  output logic [CNT_W-1:0] INSTRET
);

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_set_illegal;
  logic   w_retire;
  logic   w_unused_funct7_5;

  // ALU function decode happens downstream in ALUcontrol
  assign w_unused_funct7_5 = FUNCT7_5;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_retire      = 1'b0;
    MEM_REQ       = 1'b0;
    MEM_RW        = 1'b0;
    I_OR_D        = 1'b0;
    IR_WE         = 1'b0;
    PC_WE         = 1'b0;
    PC_SRC        = 1'b0;
    REG_WE        = 1'b0;
    MEMTOREG      = 1'b0;
    ALU_SRC_A     = SRCA_PC;
    ALU_SRC_B     = SRCB_RS2;
    ALU_OP        = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        MEM_REQ   = 1'b1;
        ALU_SRC_B = SRCB_FOUR;
        IR_WE     = MEM_READY;
        PC_WE     = MEM_READY;
        if (MEM_READY) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALU_SRC_A = SRCA_OLDPC;
        ALU_SRC_B = SRCB_IMM;
        case (OPCODE)
          OP_R:               w_next = S_EXEC_R;
          OP_I:               w_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  w_next = S_ADDR;
          OP_BRANCH: begin
            if (FUNCT3 == F3_BEQ || FUNCT3 == F3_BNE) begin
              w_next = S_BRANCH;
            end else begin
              w_set_illegal = 1'b1;
              w_next        = S_FETCH;
            end
          end
          default: begin
            w_set_illegal = 1'b1;
            w_next        = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        ALU_SRC_A = SRCA_RS1;
        ALU_SRC_B = SRCB_RS2;
        ALU_OP    = ALU_FUNCT;
        w_next    = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALU_SRC_A = SRCA_RS1;
        ALU_SRC_B = SRCB_IMM;
        ALU_OP    = ALU_FUNCT;
        w_next    = S_WB_ALU;
      end
      S_ADDR: begin
        ALU_SRC_A = SRCA_RS1;
        ALU_SRC_B = SRCB_IMM;
        w_next    = (OPCODE == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MEM_REQ = 1'b1;
        I_OR_D  = 1'b1;
        if (MEM_READY) w_next = S_WB_MEM;
      end
      S_MEM_WR: begin
        MEM_REQ = 1'b1;
        MEM_RW  = 1'b1;
        I_OR_D  = 1'b1;
        if (MEM_READY) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_WB_ALU: begin
        REG_WE   = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_WB_MEM: begin
        REG_WE   = 1'b1;
        MEMTOREG = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALU_SRC_A = SRCA_RS1;
        ALU_SRC_B = SRCB_RS2;
        ALU_OP    = ALU_SUB;
        PC_SRC    = 1'b1;
        PC_WE     = (FUNCT3 == F3_BEQ) ? ZERO : ~ZERO;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // Reset silences every strobe immediately, not just at the next edge
    if (!RST) begin
      w_set_illegal = 1'b0;
      w_retire      = 1'b0;
      MEM_REQ       = 1'b0;
      MEM_RW        = 1'b0;
      I_OR_D        = 1'b0;
      IR_WE         = 1'b0;
      PC_WE         = 1'b0;
      PC_SRC        = 1'b0;
      REG_WE        = 1'b0;
      MEMTOREG      = 1'b0;
      ALU_SRC_A     = '0;
      ALU_SRC_B     = '0;
      ALU_OP        = '0;
    end
  end

  assign STATE   = r_state;
  assign ILLEGAL = r_illegal;

  multicycle_control_retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_inc   (w_retire),
    .o_count (INSTRET)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control, plus hand sequences for
// mid-transaction reset and counter wrap on a 4-bit instance.
module tb_multicycle_control;

  localparam logic [6:0] OPR = 7'h33, OPI = 7'h13, OPL = 7'h03;
  localparam logic [6:0] OPS = 7'h23, OPB = 7'h63, OPX = 7'h7F;

  // {req,rw,iord,irwe, pcwe,pcsrc,regwe,m2r, srca, srcb, aluop}
  localparam logic [13:0] C_ZERO  = 14'b0000_0000_00_00_00;
  localparam logic [13:0] C_FE_R  = 14'b1001_1000_00_01_00;
  localparam logic [13:0] C_FE_W  = 14'b1000_0000_00_01_00;
  localparam logic [13:0] C_DEC   = 14'b0000_0000_01_10_00;
  localparam logic [13:0] C_EXR   = 14'b0000_0000_10_00_10;
  localparam logic [13:0] C_EXI   = 14'b0000_0000_10_10_10;
  localparam logic [13:0] C_ADDR  = 14'b0000_0000_10_10_00;
  localparam logic [13:0] C_MRD   = 14'b1010_0000_00_00_00;
  localparam logic [13:0] C_MWR   = 14'b1110_0000_00_00_00;
  localparam logic [13:0] C_WBA   = 14'b0000_0010_00_00_00;
  localparam logic [13:0] C_WBM   = 14'b0000_0011_00_00_00;
  localparam logic [13:0] C_BR_T  = 14'b0000_1100_10_00_01;
  localparam logic [13:0] C_BR_N  = 14'b0000_0100_10_00_01;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [13:0] ctrl;
    logic        ill;
    logic [7:0]  ret;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [6:0]  OPCODE = '0;
  logic [2:0]  FUNCT3 = '0;
  logic        FUNCT7_5 = 1'b0;
  logic        ZERO = 1'b0;
  logic        MEM_READY = 1'b0;

  logic        MEM_REQ, MEM_RW, I_OR_D, IR_WE, PC_WE, PC_SRC, REG_WE, MEMTOREG, ILLEGAL;
  logic [1:0]  ALU_SRC_A, ALU_SRC_B, ALU_OP;
  logic [3:0]  STATE;
  logic [31:0] INSTRET;

  logic        d4_req, d4_rw, d4_iord, d4_irwe, d4_pcwe, d4_pcsrc, d4_regwe, d4_m2r, d4_ill;
  logic [1:0]  d4_srca, d4_srcb, d4_aluop;
  logic [3:0]  d4_state;
  logic [3:0]  d4_instret;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  vec_t        tbl[$];

  always #5 CLK = ~CLK;

  multicycle_control dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7_5(FUNCT7_5),
    .ZERO(ZERO), .MEM_READY(MEM_READY), .MEM_REQ(MEM_REQ), .MEM_RW(MEM_RW),
    .I_OR_D(I_OR_D), .IR_WE(IR_WE), .PC_WE(PC_WE), .PC_SRC(PC_SRC), .REG_WE(REG_WE),
    .MEMTOREG(MEMTOREG), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP),
    .ILLEGAL(ILLEGAL), .STATE(STATE), .INSTRET(INSTRET)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7_5(FUNCT7_5),
    .ZERO(ZERO), .MEM_READY(MEM_READY), .MEM_REQ(d4_req), .MEM_RW(d4_rw),
    .I_OR_D(d4_iord), .IR_WE(d4_irwe), .PC_WE(d4_pcwe), .PC_SRC(d4_pcsrc), .REG_WE(d4_regwe),
    .MEMTOREG(d4_m2r), .ALU_SRC_A(d4_srca), .ALU_SRC_B(d4_srcb), .ALU_OP(d4_aluop),
    .ILLEGAL(d4_ill), .STATE(d4_state), .INSTRET(d4_instret)
  );

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic z, logic rdy,
                              logic [3:0] st, logic [13:0] ctrl, logic ill, logic [7:0] ret);
    vec_t v;
    v.op = op; v.f3 = f3; v.zero = z; v.rdy = rdy;
    v.st = st; v.ctrl = ctrl; v.ill = ill; v.ret = ret;
    return v;
  endfunction

  function automatic logic [26:0] observe();
    return {STATE, MEM_REQ, MEM_RW, I_OR_D, IR_WE, PC_WE, PC_SRC, REG_WE, MEMTOREG,
            ALU_SRC_A, ALU_SRC_B, ALU_OP, ILLEGAL, INSTRET[7:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs on the falling edge and let outputs settle before sampling.
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic rdy);
    @(negedge CLK);
    OPCODE = op; FUNCT3 = f3; ZERO = z; MEM_READY = rdy;
    #1;
  endtask

  task automatic run_addi();
    drive(OPI, 3'b000, 1'b0, 1'b1);
    drive(OPI, 3'b000, 1'b0, 1'b1);
    drive(OPI, 3'b000, 1'b0, 1'b1);
    drive(OPI, 3'b000, 1'b0, 1'b1);
  endtask

  initial begin
    // add
    tbl.push_back(mk(OPR, 3'b000, 0, 1, 4'd0, C_FE_R, 0, 8'd0));
    tbl.push_back(mk(OPR, 3'b000, 0, 0, 4'd1, C_DEC,  0, 8'd0));
    tbl.push_back(mk(OPR, 3'b000, 0, 1, 4'd2, C_EXR,  0, 8'd0));
    tbl.push_back(mk(OPR, 3'b000, 0, 0, 4'd7, C_WBA,  0, 8'd0));
    // lw with three wait cycles
    tbl.push_back(mk(OPL, 3'b010, 0, 1, 4'd0, C_FE_R, 0, 8'd1));
    tbl.push_back(mk(OPL, 3'b010, 0, 1, 4'd1, C_DEC,  0, 8'd1));
    tbl.push_back(mk(OPL, 3'b010, 0, 1, 4'd4, C_ADDR, 0, 8'd1));
    tbl.push_back(mk(OPL, 3'b010, 0, 0, 4'd5, C_MRD,  0, 8'd1));
    tbl.push_back(mk(OPL, 3'b010, 0, 0, 4'd5, C_MRD,  0, 8'd1));
    tbl.push_back(mk(OPL, 3'b010, 0, 0, 4'd5, C_MRD,  0, 8'd1));
    tbl.push_back(mk(OPL, 3'b010, 0, 1, 4'd5, C_MRD,  0, 8'd1));
    tbl.push_back(mk(OPL, 3'b010, 0, 0, 4'd8, C_WBM,  0, 8'd1));
    // sw with a fetch wait and a write wait
    tbl.push_back(mk(OPS, 3'b010, 0, 0, 4'd0, C_FE_W, 0, 8'd2));
    tbl.push_back(mk(OPS, 3'b010, 0, 1, 4'd0, C_FE_R, 0, 8'd2));
    tbl.push_back(mk(OPS, 3'b010, 0, 1, 4'd1, C_DEC,  0, 8'd2));
    tbl.push_back(mk(OPS, 3'b010, 0, 1, 4'd4, C_ADDR, 0, 8'd2));
    tbl.push_back(mk(OPS, 3'b010, 0, 0, 4'd6, C_MWR,  0, 8'd2));
    tbl.push_back(mk(OPS, 3'b010, 0, 1, 4'd6, C_MWR,  0, 8'd2));
    // addi
    tbl.push_back(mk(OPI, 3'b000, 0, 1, 4'd0, C_FE_R, 0, 8'd3));
    tbl.push_back(mk(OPI, 3'b000, 0, 1, 4'd1, C_DEC,  0, 8'd3));
    tbl.push_back(mk(OPI, 3'b000, 0, 0, 4'd3, C_EXI,  0, 8'd3));
    tbl.push_back(mk(OPI, 3'b000, 0, 1, 4'd7, C_WBA,  0, 8'd3));
    // beq/bne with ZERO=1 then ZERO=0
    tbl.push_back(mk(OPB, 3'b000, 1, 1, 4'd0, C_FE_R, 0, 8'd4));
    tbl.push_back(mk(OPB, 3'b000, 1, 1, 4'd1, C_DEC,  0, 8'd4));
    tbl.push_back(mk(OPB, 3'b000, 1, 0, 4'd9, C_BR_T, 0, 8'd4));
    tbl.push_back(mk(OPB, 3'b001, 1, 1, 4'd0, C_FE_R, 0, 8'd5));
    tbl.push_back(mk(OPB, 3'b001, 1, 1, 4'd1, C_DEC,  0, 8'd5));
    tbl.push_back(mk(OPB, 3'b001, 1, 1, 4'd9, C_BR_N, 0, 8'd5));
    tbl.push_back(mk(OPB, 3'b000, 0, 1, 4'd0, C_FE_R, 0, 8'd6));
    tbl.push_back(mk(OPB, 3'b000, 0, 1, 4'd1, C_DEC,  0, 8'd6));
    tbl.push_back(mk(OPB, 3'b000, 0, 1, 4'd9, C_BR_N, 0, 8'd6));
    tbl.push_back(mk(OPB, 3'b001, 0, 1, 4'd0, C_FE_R, 0, 8'd7));
    tbl.push_back(mk(OPB, 3'b001, 0, 1, 4'd1, C_DEC,  0, 8'd7));
    tbl.push_back(mk(OPB, 3'b001, 0, 1, 4'd9, C_BR_T, 0, 8'd7));
    // illegal opcode, then an add proving execution continues with ILLEGAL sticky
    tbl.push_back(mk(OPX, 3'b000, 0, 1, 4'd0, C_FE_R, 0, 8'd8));
    tbl.push_back(mk(OPX, 3'b000, 0, 1, 4'd1, C_DEC,  0, 8'd8));
    tbl.push_back(mk(OPR, 3'b000, 0, 1, 4'd0, C_FE_R, 1, 8'd8));
    tbl.push_back(mk(OPR, 3'b000, 0, 1, 4'd1, C_DEC,  1, 8'd8));
    tbl.push_back(mk(OPR, 3'b000, 0, 1, 4'd2, C_EXR,  1, 8'd8));
    tbl.push_back(mk(OPR, 3'b000, 0, 1, 4'd7, C_WBA,  1, 8'd8));
    // branch with unsupported funct3
    tbl.push_back(mk(OPB, 3'b010, 0, 1, 4'd0, C_FE_R, 1, 8'd9));
    tbl.push_back(mk(OPB, 3'b010, 0, 1, 4'd1, C_DEC,  1, 8'd9));
    tbl.push_back(mk(OPB, 3'b010, 0, 0, 4'd0, C_FE_W, 1, 8'd9));

    // reset state while RST is held
    drive(OPR, 3'b000, 1'b0, 1'b1);
    check("reset_outputs", 64'(observe()), 64'({4'd0, C_ZERO, 1'b0, 8'd0}));
    check("reset_instret4", 64'(d4_instret), 64'd0);
    @(negedge CLK);
    MEM_READY = 1'b0;
    RST = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].f3, tbl[i].zero, tbl[i].rdy);
      check($sformatf("vec[%0d]", i), 64'(observe()),
            64'({tbl[i].st, tbl[i].ctrl, tbl[i].ill, tbl[i].ret}));
    end

    // reset asserted mid MEM_WR while the memory is stalled
    drive(OPS, 3'b010, 1'b0, 1'b1);
    drive(OPS, 3'b010, 1'b0, 1'b1);
    drive(OPS, 3'b010, 1'b0, 1'b1);
    drive(OPS, 3'b010, 1'b0, 1'b0);
    check("memwr_state", 64'(STATE), 64'd6);
    check("memwr_req", 64'(MEM_REQ), 64'd1);
    #2;
    RST = 1'b0;
    MEM_READY = 1'b1;
    #1;
    check("rst_mid_req", 64'(MEM_REQ), 64'd0);
    check("rst_mid_state", 64'(STATE), 64'd0);
    check("rst_mid_instret", 64'(INSTRET), 64'd0);
    check("rst_mid_illegal", 64'(ILLEGAL), 64'd0);
    drive(OPS, 3'b010, 1'b0, 1'b0);
    check("rst_hold_outputs", 64'(observe()), 64'({4'd0, C_ZERO, 1'b0, 8'd0}));
    RST = 1'b1;

    // 4-bit counter wraps 15 -> 0 on the 16th retire
    for (int k = 0; k < 15; k++) run_addi();
    drive(OPI, 3'b000, 1'b0, 1'b0);
    check("wrap_at15", 64'(d4_instret), 64'd15);
    run_addi();
    drive(OPI, 3'b000, 1'b0, 1'b0);
    check("wrap_to0", 64'(d4_instret), 64'd0);
    check("instret32_16", 64'(INSTRET), 64'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
